// File: rtl/hi_14a_pkg.sv
// rtl/hi_14a_pkg.sv - shared types and constants for the ISO 14443A reader receive path
// Purpose: receiver state encoding, air-interface timing constants and the odd-parity helper.
// Ports: none (package).
package hi_14a_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2
  } rx_state_t;

  localparam int SUBC_CLKS    = 16;   // one fc/16 subcarrier period = one detection window
  localparam int BIT_CLKS     = 128;  // fc/128 bit period
  localparam int WIN_PER_HALF = BIT_CLKS / (2 * SUBC_CLKS);
  localparam int DATA_BITS    = 8;

  // High when data plus parity bit do not contain an odd number of ones.
  function automatic logic odd_parity_err(input logic [7:0] data, input logic parity);
    return ~(^{data, parity});
  endfunction

endpackage

// File: rtl/hi_14a_subcarrier_detect.sv
// rtl/hi_14a_subcarrier_detect.sv - per-window subcarrier presence detector
// Purpose: tracks min/max of adc_d over 16-sample windows and flags windows whose
//          peak-to-peak swing reaches THRESH.
// Ports:
//   clk      in   carrier clock
//   reset    in   synchronous active-high reset
//   restart  in   realign the window counter (next sample becomes sample 0)
//   adc_d    in   8-bit peak-detector sample
//   win_done out  high during the cycle that samples the 16th value of a window
//   win_mod  out  window swing >= THRESH, qualified by win_done
module hi_14a_subcarrier_detect
  import hi_14a_pkg::*;
#(
  parameter int THRESH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [7:0] adc_d,
  output logic       win_done,
  output logic       win_mod
);

  logic [3:0] wcnt;
  logic [7:0] min_q, max_q;
  logic [7:0] min_c, max_c;
  logic [8:0] span;

  // Sample 0 of each window reloads the trackers, so the decision at the last
  // sample covers exactly this window's 16 values including the current one.
  always_comb begin
    if (wcnt == 4'd0) begin
      min_c = adc_d;
      max_c = adc_d;
    end else begin
      min_c = (adc_d < min_q) ? adc_d : min_q;
      max_c = (adc_d > max_q) ? adc_d : max_q;
    end
    span = {1'b0, max_c} - {1'b0, min_c};
  end

  assign win_done = (wcnt == 4'(SUBC_CLKS - 1));
  assign win_mod  = win_done && (span >= 9'(THRESH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt  <= 4'd0;
      min_q <= 8'd0;
      max_q <= 8'd0;
    end else begin
      min_q <= min_c;
      max_q <= max_c;
      wcnt  <= restart ? 4'd0 : wcnt + 4'd1;
    end
  end

endmodule

// File: rtl/hi_14a_reader_rx.sv
// rtl/hi_14a_reader_rx.sv - ISO 14443A reader receive path (subcarrier demod + Manchester byte decode)
// Purpose: turns subcarrier windows into half-bit decisions, decodes start bit, data
//          bytes with odd parity, collisions and end of frame into byte/frame strobes.
// Ports:
//   ck_1356meg    in   13.56 MHz carrier clock
//   reset         in   synchronous active-high reset
//   enable        in   receiver armed; low forces IDLE
//   adc_d         in   peak-detector sample
//   adc_clk       out  ADC sample clock (the carrier clock)
//   rx_data       out  received byte, LSB first on air
//   rx_nbits      out  valid bits in rx_data (1..8)
//   rx_parity     out  received parity bit
//   rx_parity_err out  odd-parity check failed
//   rx_collision  out  some bit of the byte had both halves modulated
//   rx_valid      out  1-cycle strobe for the rx_* fields
//   rx_eof        out  1-cycle end-of-frame strobe
//   rx_busy       out  frame reception in progress
module hi_14a_reader_rx
  import hi_14a_pkg::*;
#(
  parameter int THRESH = 8,
  parameter int MAJ    = 3
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] adc_d,
  output logic       adc_clk,
  output logic [7:0] rx_data,
  output logic [3:0] rx_nbits,
  output logic       rx_parity,
  output logic       rx_parity_err,
  output logic       rx_collision,
  output logic       rx_valid,
  output logic       rx_eof,
  output logic       rx_busy
);

  rx_state_t  state, state_n;
  logic [1:0] pcnt, pcnt_n;
  logic [2:0] mcnt, mcnt_n, mcnt_sum;
  logic       second_half, second_half_n;
  logic       h1, h1_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic       coll, coll_n;

  logic [7:0] rx_data_n;
  logic [3:0] rx_nbits_n;
  logic       rx_parity_n, rx_parity_err_n, rx_collision_n, rx_valid_n, rx_eof_n;

  logic win_done, win_mod, half_end, half_mod, bit_coll, sof_hit;

  assign adc_clk = ck_1356meg;
  assign rx_busy = (state != ST_IDLE);

  hi_14a_subcarrier_detect #(
    .THRESH (THRESH)
  ) u_detect (
    .clk      (ck_1356meg),
    .reset    (reset),
    .restart  (sof_hit),
    .adc_d    (adc_d),
    .win_done (win_done),
    .win_mod  (win_mod)
  );

  always_comb begin
    mcnt_sum = mcnt + {2'b00, win_mod};
    half_mod = (mcnt_sum >= 3'(MAJ));
    half_end = win_done && (pcnt == 2'(WIN_PER_HALF - 1));
    bit_coll = h1 && half_mod;

    state_n         = state;
    pcnt_n          = pcnt;
    mcnt_n          = mcnt;
    second_half_n   = second_half;
    h1_n            = h1;
    bitcnt_n        = bitcnt;
    shreg_n         = shreg;
    coll_n          = coll;
    rx_data_n       = rx_data;
    rx_nbits_n      = rx_nbits;
    rx_parity_n     = rx_parity;
    rx_parity_err_n = rx_parity_err;
    rx_collision_n  = rx_collision;
    rx_valid_n      = 1'b0;
    rx_eof_n        = 1'b0;
    sof_hit         = 1'b0;

    if (!enable) begin
      state_n       = ST_IDLE;
      pcnt_n        = 2'd0;
      mcnt_n        = 3'd0;
      second_half_n = 1'b0;
      h1_n          = 1'b0;
      bitcnt_n      = 4'd0;
      shreg_n       = 8'd0;
      coll_n        = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The triggering window is already window 0 of the start bit's first half.
          if (win_done && win_mod) begin
            state_n       = ST_SOF;
            pcnt_n        = 2'd1;
            mcnt_n        = 3'd1;
            second_half_n = 1'b0;
            sof_hit       = 1'b1;
          end
        end
        ST_SOF, ST_DATA: begin
          if (win_done) begin
            if (half_end) begin
              pcnt_n = 2'd0;
              mcnt_n = 3'd0;
            end else begin
              pcnt_n = pcnt + 2'd1;
              mcnt_n = mcnt_sum;
            end
            if (half_end && !second_half) begin
              h1_n          = half_mod;
              second_half_n = 1'b1;
            end
            if (half_end && second_half) begin
              second_half_n = 1'b0;
              if (state == ST_SOF) begin
                state_n  = (h1 && !half_mod) ? ST_DATA : ST_IDLE;
                bitcnt_n = 4'd0;
              end else if (!h1 && !half_mod) begin
                // No modulation in either half: end of frame, flush any partial byte.
                state_n  = ST_IDLE;
                rx_eof_n = 1'b1;
                if (bitcnt != 4'd0) begin
                  rx_valid_n      = 1'b1;
                  rx_data_n       = shreg;
                  rx_nbits_n      = bitcnt;
                  rx_parity_n     = 1'b0;
                  rx_parity_err_n = 1'b0;
                  rx_collision_n  = coll;
                end
                bitcnt_n = 4'd0;
                shreg_n  = 8'd0;
                coll_n   = 1'b0;
              end else if (bitcnt == 4'(DATA_BITS)) begin
                // Ninth bit of a byte is the parity bit; the bit value is the first half.
                rx_valid_n      = 1'b1;
                rx_data_n       = shreg;
                rx_nbits_n      = 4'(DATA_BITS);
                rx_parity_n     = h1;
                rx_parity_err_n = odd_parity_err(shreg, h1);
                rx_collision_n  = coll | bit_coll;
                bitcnt_n        = 4'd0;
                shreg_n         = 8'd0;
                coll_n          = 1'b0;
              end else begin
                shreg_n[bitcnt[2:0]] = h1;
                bitcnt_n             = bitcnt + 4'd1;
                coll_n               = coll | bit_coll;
              end
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state         <= ST_IDLE;
      pcnt          <= 2'd0;
      mcnt          <= 3'd0;
      second_half   <= 1'b0;
      h1            <= 1'b0;
      bitcnt        <= 4'd0;
      shreg         <= 8'd0;
      coll          <= 1'b0;
      rx_data       <= 8'd0;
      rx_nbits      <= 4'd0;
      rx_parity     <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_collision  <= 1'b0;
      rx_valid      <= 1'b0;
      rx_eof        <= 1'b0;
    end else begin
      state         <= state_n;
      pcnt          <= pcnt_n;
      mcnt          <= mcnt_n;
      second_half   <= second_half_n;
      h1            <= h1_n;
      bitcnt        <= bitcnt_n;
      shreg         <= shreg_n;
      coll          <= coll_n;
      rx_data       <= rx_data_n;
      rx_nbits      <= rx_nbits_n;
      rx_parity     <= rx_parity_n;
      rx_parity_err <= rx_parity_err_n;
      rx_collision  <= rx_collision_n;
      rx_valid      <= rx_valid_n;
      rx_eof        <= rx_eof_n;
    end
  end

endmodule
